// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store unit data-memory controller:
// access length codes, controller states and a length-to-byte-count helper.
package riscv_mem_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } lsu_state_t;

    // Number of bytes touched by an access; the reserved code 2'b11 behaves as a word.
    function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            LEN_WORD: return 3'd4;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables and store data for the first
// and (when the access crosses a word boundary) second bus beat, plus merging
// and sign/zero extension of load data. Purely combinational.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  length,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic        split,
    output logic [3:0]  be_first,
    output logic [3:0]  be_second,
    output logic [31:0] wdata_first,
    output logic [31:0] wdata_second,
    output logic [31:0] rdata
);

    logic [3:0]  lane_mask;
    logic [7:0]  be_span;
    logic [63:0] wdata_span;
    logic [31:0] rd_merged;

    // Lay the access across an 8-lane window; lanes 4..7 spill into the next word.
    always_comb begin
        case (len_to_nbytes(length))
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        be_span      = {4'b0000, lane_mask} << offset;
        wdata_span   = {32'h0000_0000, wdata} << {offset, 3'b000};
        split        = |be_span[7:4];
        be_first     = be_span[3:0];
        be_second    = be_span[7:4];
        wdata_first  = wdata_span[31:0];
        wdata_second = wdata_span[63:32];
    end

    // Shift the fetched word pair so the addressed byte sits in lane 0, then extend.
    always_comb begin
        rd_merged = 32'({rd_hi, rd_lo} >> {offset, 3'b000});
        case (length)
            LEN_BYTE: rdata = load_unsigned ? {24'h00_0000, rd_merged[7:0]}
                                            : {{24{rd_merged[7]}}, rd_merged[7:0]};
            LEN_HALF: rdata = load_unsigned ? {16'h0000, rd_merged[15:0]}
                                            : {{16{rd_merged[15]}}, rd_merged[15:0]};
            default:  rdata = rd_merged;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Data-memory side of the load/store path. Turns a byte/half/word load or
// store into one or two word-aligned bus beats with a valid/ready handshake,
// stalls the core until completion and returns extended load data.
// Optional feature: define MISALIGN_SPLIT_EN to service accesses that cross a
// word boundary as two beats; otherwise they are rejected with misalign_err.
module lsu_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          mem_write,
    input  logic [1:0]    length,
    input  logic          load_unsigned,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          misalign_err,
    output logic          m_valid,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_be,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata
);

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_t    state_q, state_d;
    logic          mem_write_q, mem_write_d;
    logic [1:0]    length_q, length_d;
    logic          load_unsigned_q, load_unsigned_d;
    logic [1:0]    offset_q, offset_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          m_valid_q, m_valid_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [3:0]    m_be_q, m_be_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          done_q, done_d;
    logic          misalign_err_q, misalign_err_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [1:0]    sel_offset;
    logic [1:0]    sel_length;
    logic [DW-1:0] sel_wdata;
    logic [DW-1:0] rd_lo;
    logic          al_split;
    logic [3:0]    al_be_first;
    logic [3:0]    al_be_second;
    logic [DW-1:0] al_wdata_first;
    logic [DW-1:0] al_wdata_second;
    logic [DW-1:0] al_rdata;

    // In IDLE the aligner sees the live request so beat one registers at once; later it sees the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            sel_offset = addr[1:0];
            sel_length = length;
            sel_wdata  = wdata;
        end else begin
            sel_offset = offset_q;
            sel_length = length_q;
            sel_wdata  = wdata_q;
        end
        rd_lo = (state_q == ACC1) ? hold_q : m_rdata;
    end

    lsu_align u_align (
        .offset        (sel_offset),
        .length        (sel_length),
        .load_unsigned (load_unsigned_q),
        .wdata         (sel_wdata),
        .rd_lo         (rd_lo),
        .rd_hi         (m_rdata),
        .split         (al_split),
        .be_first      (al_be_first),
        .be_second     (al_be_second),
        .wdata_first   (al_wdata_first),
        .wdata_second  (al_wdata_second),
        .rdata         (al_rdata)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d         = state_q;
        mem_write_d     = mem_write_q;
        length_d        = length_q;
        load_unsigned_d = load_unsigned_q;
        offset_d        = offset_q;
        wdata_d         = wdata_q;
        hold_d          = hold_q;
        m_valid_d       = m_valid_q;
        m_we_d          = m_we_q;
        m_addr_d        = m_addr_q;
        m_be_d          = m_be_q;
        m_wdata_d       = m_wdata_q;
        done_d          = 1'b0;
        misalign_err_d  = 1'b0;
        rdata_d         = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_write_d     = mem_write;
                    length_d        = length;
                    load_unsigned_d = load_unsigned;
                    offset_d        = addr[1:0];
                    wdata_d         = wdata;
                    if (al_split && !SPLIT_EN) begin
                        state_d        = RESP;
                        done_d         = 1'b1;
                        misalign_err_d = 1'b1;
                    end else begin
                        state_d   = ACC0;
                        m_valid_d = 1'b1;
                        m_we_d    = mem_write;
                        m_addr_d  = {addr[AW-1:2], 2'b00};
                        m_be_d    = al_be_first;
                        m_wdata_d = al_wdata_first;
                    end
                end
            end
            ACC0: begin
                if (m_ready) begin
                    hold_d = m_rdata;
                    if (al_split) begin
                        state_d   = ACC1;
                        m_addr_d  = m_addr_q + AW'(4);
                        m_be_d    = al_be_second;
                        m_wdata_d = al_wdata_second;
                    end else begin
                        state_d   = RESP;
                        m_valid_d = 1'b0;
                        m_we_d    = 1'b0;
                        done_d    = 1'b1;
                        rdata_d   = mem_write_q ? '0 : al_rdata;
                    end
                end
            end
            ACC1: begin
                if (m_ready) begin
                    state_d   = RESP;
                    m_valid_d = 1'b0;
                    m_we_d    = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = mem_write_q ? '0 : al_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One register bank for state, latched request, bus outputs and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            mem_write_q     <= 1'b0;
            length_q        <= 2'b00;
            load_unsigned_q <= 1'b0;
            offset_q        <= 2'b00;
            wdata_q         <= '0;
            hold_q          <= '0;
            m_valid_q       <= 1'b0;
            m_we_q          <= 1'b0;
            m_addr_q        <= '0;
            m_be_q          <= 4'b0000;
            m_wdata_q       <= '0;
            done_q          <= 1'b0;
            misalign_err_q  <= 1'b0;
            rdata_q         <= '0;
        end else begin
            state_q         <= state_d;
            mem_write_q     <= mem_write_d;
            length_q        <= length_d;
            load_unsigned_q <= load_unsigned_d;
            offset_q        <= offset_d;
            wdata_q         <= wdata_d;
            hold_q          <= hold_d;
            m_valid_q       <= m_valid_d;
            m_we_q          <= m_we_d;
            m_addr_q        <= m_addr_d;
            m_be_q          <= m_be_d;
            m_wdata_q       <= m_wdata_d;
            done_q          <= done_d;
            misalign_err_q  <= misalign_err_d;
            rdata_q         <= rdata_d;
        end
    end

    assign stall        = req_valid & ~done_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign misalign_err = misalign_err_q;
    assign m_valid      = m_valid_q;
    assign m_we         = m_we_q;
    assign m_addr       = m_addr_q;
    assign m_be         = m_be_q;
    assign m_wdata      = m_wdata_q;

endmodule
